// File: rtl/output_port_arbiter.sv
// Round-robin output-port scheduler: pops one of four queues in bounded bursts onto a valid/ready
// output. Define OUTPUT_ARB_STATS_EN to build the per-queue 16-bit word counters on stat_cnt.
module output_port_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W:0]   req_0,
  input  logic [DATA_W:0]   req_1,
  input  logic [DATA_W:0]   req_2,
  input  logic [DATA_W:0]   req_3,
  output logic [3:0]        rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [63:0]       stat_cnt
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic [DATA_W:0]     req [4];
  logic [3:0]          req_vld;
  logic [DATA_W:0]     req_grant;
  logic [3:0]          burst_inc;
  logic                pick_found;
  logic [1:0]          pick_idx;
  logic [1:0]          cand;

  assign req[0] = req_0;
  assign req[1] = req_1;
  assign req[2] = req_2;
  assign req[3] = req_3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_vld[i] = req[i][DATA_W];
    end
  end

  assign req_grant = req[grant_q];
  assign burst_inc = burst_cnt_q + 4'd1;

  // First valid queue starting at rr_ptr and wrapping modulo 4.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!pick_found && req_vld[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d     = pick_idx;
          burst_cnt_d = 4'd0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        out_data_d  = req_grant[DATA_W-1:0];
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          burst_cnt_d = burst_inc;
          // req_grant already shows the head left behind by the LOAD pop.
          if ((32'(burst_inc) < MAX_BURST) && req_grant[DATA_W]) begin
            state_d = StLoad;
          end else begin
            rr_ptr_d = grant_q + 2'd1;
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      grant_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      burst_cnt_q <= 4'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    rd_en = 4'b0000;
    if (state_q == StLoad) begin
      rd_en[grant_q] = 1'b1;
    end
  end

  assign busy      = (state_q != StIdle);
  assign grant     = grant_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef OUTPUT_ARB_STATS_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if ((state_q == StLoad) && (cnt_q[grant_q] != 16'hFFFF)) begin
      cnt_d[grant_q] = cnt_q[grant_q] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stat_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign stat_cnt = 64'd0;
`endif

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Round-robin scheduler for one output port of the 4x4 switch. It arbitrates between the four per-input queues that target this output, and pops the granted queue through its read enable. It presents the popped word on a valid/ready output interface and limits each grant to a bounded burst before rotating. One instance sits between the four queues feeding an output and that output's port logic.

## Interface
- DATA_W, 32: payload width; queue words are DATA_W+1 bits.
- MAX_BURST, 4: maximum words taken from one queue per grant; legal range 1..15.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- req_0..req_3  in  DATA_W+1 each  queue head words; bit DATA_W = head valid (queue non-empty), bits DATA_W-1:0 = head payload.
- rd_en  out  4  one-hot pop strobe; bit i pops queue i at the next rising edge.
- out_data  out  DATA_W  popped payload.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  downstream accepts out_data when high with out_valid.
- grant  out  2  index of the queue currently granted.
- busy  out  1  high in any state other than IDLE.
- stat_cnt  out  64  four 16-bit per-queue word counters; {cnt3,cnt2,cnt1,cnt0}.

## Operation
- FSM states are IDLE, LOAD and HOLD. Registers are state, grant, rr_ptr[1:0], burst_cnt[3:0], out_data and out_valid.
- IDLE: when any req_i[DATA_W] is high, grant <= first valid index searching rr_ptr, rr_ptr+1, ... modulo 4. burst_cnt <= 0 and state goes to LOAD. With no request, the FSM stays in IDLE.
- LOAD: rd_en[grant] = 1 combinationally, and only in this state.
  - out_data <= req_grant[DATA_W-1:0].
  - out_valid <= 1.
  - state goes to HOLD.
- HOLD: out_valid is held until out_ready is high. On that handshake edge:
  - out_valid <= 0 and burst_cnt <= burst_cnt+1.
  - If burst_cnt+1 < MAX_BURST and req_grant[DATA_W] is high, state goes to LOAD with the same grant.
  - Otherwise rr_ptr <= grant+1 (wraps 3 to 0) and state goes to IDLE.
- req_grant is sampled in HOLD after the LOAD pop edge, so it reflects the new queue head.
- rd_en never has more than one bit set. rd_en is 0 in IDLE and HOLD.
- A queue whose valid bit drops in IDLE is simply not selected. Valid cannot drop in LOAD because queues pop only on rd_en.
- rst low at any time clears all state immediately:
  - state IDLE, grant 0, rr_ptr 0, burst_cnt 0.
  - out_valid 0, out_data 0, rd_en 0, busy 0, stat_cnt 0.
  - A word held in HOLD is discarded.

## Timing
- Request to pop: req valid in IDLE at cycle 0, so rd_en is high in cycle 1 (LOAD) and out_valid is high from cycle 2.
- Best-case throughput is one word per 2 cycles (LOAD, HOLD with out_ready=1).
- out_ready low stalls in HOLD indefinitely. No pop occurs while stalled.
- Rotation: after a grant ends, the next IDLE decision starts at grant+1. Every continuously requesting queue is served within 3 other grants.
- Gap between grants is one IDLE cycle.
- All outputs are registered except rd_en and busy, which are decoded from state.

## Configuration
- OUTPUT_ARB_STATS_EN defined: stat_cnt holds four 16-bit counters. Counter i increments on each LOAD with grant==i and saturates at 16'hFFFF. Counters clear only on reset.
- Not defined: no counter registers are built and stat_cnt is tied to 0.
- Arbitration behaviour is identical in both builds.

## Test plan
- Reset: hold rst=0 with all queues valid. Required: rd_en=0, out_valid=0, busy=0, out_data=0. After release, the first grant is queue 0 with rd_en=4'b0001 in the second cycle.
- Single queue: queue 2 holds 3 words A, B, C, out_ready=1, MAX_BURST=4. Required: out_data A, B, C in order, exactly 3 rd_en[2] pulses, return to IDLE, rr_ptr=3.
- Burst limit: queue 1 holds 10 words and queue 3 holds 10 words, MAX_BURST=4. Required: grant sequence 1,3,1,3 with 4 words each, never 5 consecutive pops from one queue.
- Fairness: all four queues always valid. Required: grant order 0,1,2,3,0; each grant is 4 words; rd_en is always one-hot.
- Backpressure: out_ready=0 for 10 cycles in HOLD. Required: out_valid stays 1, out_data is stable, no rd_en. The word is accepted on the first out_ready=1 edge.
- Reset mid-burst plus stats (OUTPUT_ARB_STATS_EN): pulse rst low in HOLD. Required: outputs are 0 immediately, stat_cnt=0. The next grant is queue 0, and stat_cnt[15:0] increments per pop.
